// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core, its decoder and the run controller.
// Holds the run-controller state encoding, stop-status codes and opcode field layout.
package risc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } run_state_e;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_BP      = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // The opcode occupies the top OPC_W bits of every instruction word.
    localparam int OPC_W = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_match.sv
// PC breakpoint comparator bank: flags a hit and reports the lowest matching index.
// Purely combinational so the debug top can reuse it alongside the run controller.
module bp_match
    import risc_pkg::*;
#(
    parameter int NUM_BP = 2,
    parameter int PC_W   = 16
) (
    input  logic [PC_W-1:0]               pc,
    input  logic [NUM_BP-1:0]             bp_en,
    input  logic [NUM_BP*PC_W-1:0]        bp_addr,
    output logic                          hit,
    output logic [idx_width(NUM_BP)-1:0]  idx
);

    localparam int IDX_W = idx_width(NUM_BP);

    // Scan from the top down so the lowest matching comparator is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller for the 16-bit RISC core: gates the core clock enable, counts cycles
// and stops on halt opcode, PC breakpoint, cycle budget or external abort.
module risc_run_ctrl
    import risc_pkg::*;
#(
    parameter int          PC_W        = 16,
    parameter int          INSTR_W     = 16,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int          NUM_BP      = 2,
    parameter int          CYC_W       = 32,
    parameter int unsigned MAX_CYCLES  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          step_mode,
    input  logic                          step,
    input  logic [NUM_BP-1:0]             bp_en,
    input  logic [NUM_BP*PC_W-1:0]        bp_addr,
    input  logic [PC_W-1:0]               pc,
    input  logic [INSTR_W-1:0]            instr,
    output logic                          cpu_en,
    output logic                          running,
    output logic                          done,
    output logic [1:0]                    status,
    output logic [idx_width(NUM_BP)-1:0]  bp_idx,
    output logic [CYC_W-1:0]              cycle_count
);

    localparam int               IDX_W  = idx_width(NUM_BP);
    localparam logic [CYC_W-1:0] MAX_CC = CYC_W'(MAX_CYCLES);

    run_state_e         state_q, state_d;
    logic [1:0]         status_q, status_d;
    logic [IDX_W-1:0]   bp_idx_q, bp_idx_d;
    logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;
    logic               bp_mask_q, bp_mask_d;

    logic               bp_hit;
    logic [IDX_W-1:0]   bp_hit_idx;
    logic               active;
    logic               is_halt;
    logic               bp_stop;
    logic               is_timeout;
    logic               cpu_en_c;

    bp_match #(
        .NUM_BP (NUM_BP),
        .PC_W   (PC_W)
    ) u_bp_match (
        .pc      (pc),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .hit     (bp_hit),
        .idx     (bp_hit_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            status_q      <= ST_NONE;
            bp_idx_q      <= '0;
            cycle_count_q <= '0;
            bp_mask_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            bp_idx_q      <= bp_idx_d;
            cycle_count_q <= cycle_count_d;
            bp_mask_q     <= bp_mask_d;
        end
    end

    // Stop-condition decode; bp_mask_q suppresses the breakpoint we just resumed from.
    always_comb begin
        active     = (state_q == S_RUN) && (!step_mode || step);
        is_halt    = (instr[INSTR_W-1 -: OPC_W] == HALT_OPCODE);
        bp_stop    = bp_hit && !bp_mask_q;
        is_timeout = (cycle_count_q == MAX_CC);
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        bp_idx_d      = bp_idx_q;
        cycle_count_d = cycle_count_q;
        bp_mask_d     = bp_mask_q;
        cpu_en_c      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d       = S_RUN;
                        status_d      = ST_NONE;
                        cycle_count_d = '0;
                        bp_mask_d     = 1'b0;
                    end
                end
                S_RUN: begin
                    if (active) begin
                        // Only an active cycle consumes the resume mask.
                        bp_mask_d = 1'b0;
                        if (is_halt) begin
                            state_d  = S_DONE;
                            status_d = ST_HALT;
                        end else if (bp_stop) begin
                            state_d  = S_DONE;
                            status_d = ST_BP;
                            bp_idx_d = bp_hit_idx;
                        end else if (is_timeout) begin
                            state_d  = S_DONE;
                            status_d = ST_TIMEOUT;
                        end else begin
                            cpu_en_c      = 1'b1;
                            cycle_count_d = cycle_count_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start && (status_q == ST_BP)) begin
                        state_d   = S_RUN;
                        status_d  = ST_NONE;
                        bp_mask_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign cpu_en      = cpu_en_c;
    assign running     = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign status      = status_q;
    assign bp_idx      = bp_idx_q;
    assign cycle_count = cycle_count_q;

endmodule
